// File: rtl/layer_output_serializer.sv
// Collects one layer's per-neuron activations into a capture bank, then streams them
// in neuron-index order to the next layer. The send bank lets the next frame fill in meanwhile.
module layer_output_serializer #(
  parameter int unsigned NUM_NEURONS = 30,
  parameter int unsigned IN_WIDTH    = 8,
  parameter int unsigned OUT_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_NEURONS-1:0]          neuron_valid,
  input  logic [NUM_NEURONS*IN_WIDTH-1:0] neuron_out,
  input  logic                            dout_ready,
  output logic [OUT_WIDTH-1:0]            dout,
  output logic                            dout_valid,
  output logic                            dout_last,
  output logic                            overflow,
  output logic                            busy
);

  localparam int unsigned IDX_W  = $clog2(NUM_NEURONS);
  localparam int unsigned WIDE_W = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int unsigned DROP_W = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH - OUT_WIDTH : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  // Zero-extend narrow activations; keep the upper OUT_WIDTH bits of wide ones.
  function automatic logic [OUT_WIDTH-1:0] widen(input logic [IN_WIDTH-1:0] v);
    logic [WIDE_W-1:0] w;
    w = WIDE_W'(v) >> DROP_W;
    return OUT_WIDTH'(w);
  endfunction

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_NEURONS-1:0] mask_q, mask_d;
  logic                   pending_q, pending_d;
  logic [IN_WIDTH-1:0]    cap_q  [NUM_NEURONS];
  logic [IN_WIDTH-1:0]    cap_d  [NUM_NEURONS];
  logic [OUT_WIDTH-1:0]   send_q [NUM_NEURONS];
  logic [OUT_WIDTH-1:0]   send_d [NUM_NEURONS];
  logic [OUT_WIDTH-1:0]   dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   dout_last_q, dout_last_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;

  logic                   fire_c;
  logic                   last_acc_c;
  logic [NUM_NEURONS-1:0] accept_c;
  logic [NUM_NEURONS-1:0] redo_c;
  logic [NUM_NEURONS-1:0] fresh_mask_c;
  logic                   complete_c;
  logic                   load_c;
  logic [IDX_W-1:0]       nxt_idx_c;

  // Handshake, capture acceptance and frame-transfer decision.
  always_comb begin
    fire_c       = dout_valid_q & dout_ready;
    last_acc_c   = fire_c & dout_last_q;
    accept_c     = pending_q ? '0 : (neuron_valid & ~mask_q);
    fresh_mask_c = mask_q | accept_c;
    complete_c   = ~pending_q & (&fresh_mask_c);
    load_c       = (complete_c & ((state_q == IDLE) | last_acc_c)) | (pending_q & last_acc_c);
    // A repeat pulse on the edge that empties the capture bank opens the next frame.
    redo_c       = (load_c & ~pending_q) ? (neuron_valid & mask_q) : '0;
    nxt_idx_c    = idx_q + IDX_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mask_d       = fresh_mask_c;
    pending_d    = pending_q;
    cap_d        = cap_q;
    send_d       = send_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    overflow_d   = overflow_q |
                   (pending_q ? (|neuron_valid) : (|(neuron_valid & mask_q & ~redo_c)));

    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (accept_c[i] | redo_c[i]) begin
        cap_d[i] = neuron_out[i*IN_WIDTH +: IN_WIDTH];
      end
    end

    if (load_c) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        send_d[i] = widen(accept_c[i] ? neuron_out[i*IN_WIDTH +: IN_WIDTH] : cap_q[i]);
      end
      state_d      = SEND;
      idx_d        = '0;
      mask_d       = redo_c;
      pending_d    = 1'b0;
      dout_d       = send_d[0];
      dout_valid_d = 1'b1;
      dout_last_d  = 1'b0;
    end else if (last_acc_c) begin
      state_d      = IDLE;
      idx_d        = '0;
      dout_d       = '0;
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
    end else if (fire_c) begin
      idx_d        = nxt_idx_c;
      dout_d       = send_q[nxt_idx_c];
      dout_last_d  = (nxt_idx_c == LAST_IDX);
    end

    // Frame completed while the previous one is still streaming: freeze it.
    if (complete_c & ~load_c) begin
      pending_d = 1'b1;
    end

    busy_d = (state_d == SEND) | pending_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      mask_q       <= '0;
      pending_q    <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cap_q[i]  <= '0;
        send_q[i] <= '0;
      end
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      cap_q        <= cap_d;
      send_q       <= send_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: directed scenarios plus random traffic,
// compared every cycle against a frame-queue reference model.
module tb_layer_output_serializer;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 8;
  localparam int unsigned OW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    nv;
  logic [N*IW-1:0] nout;
  logic            rdy;
  logic [OW-1:0]   dout;
  logic            dout_valid;
  logic            dout_last;
  logic            overflow;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words still to stream for the current frame, plus capture state.
  logic [OW-1:0] q[$];
  logic [IW-1:0] m_cap [N];
  logic [N-1:0]  m_mask;
  bit            m_pend;
  logic [OW-1:0] m_pframe [N];
  bit            m_ovf;

  layer_output_serializer #(.NUM_NEURONS(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk          (clk),
    .rst          (rst),
    .neuron_valid (nv),
    .neuron_out   (nout),
    .dout_ready   (rdy),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_last    (dout_last),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*IW-1:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] e);
    return {e, c, b, a};
  endfunction

  task automatic model_reset();
    q.delete();
    m_mask = '0;
    m_pend = 1'b0;
    m_ovf  = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cap[i]    = '0;
      m_pframe[i] = '0;
    end
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N*IW-1:0] d, input logic r);
    bit            fire, last_acc, complete, pend_old;
    logic [N-1:0]  dup, mnew;
    logic [IW-1:0] cnew [N];
    pend_old = m_pend;
    fire     = (q.size() > 0) && r;
    last_acc = fire && (q.size() == 1);
    dup      = '0;
    mnew     = m_mask;
    for (int i = 0; i < N; i++) cnew[i] = m_cap[i];
    if (pend_old) begin
      if (v != '0) m_ovf = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          if (m_mask[i]) dup[i] = 1'b1;
          else begin
            mnew[i] = 1'b1;
            cnew[i] = d[i*IW +: IW];
          end
        end
      end
    end
    complete = !pend_old && (mnew == '1);
    if (fire) void'(q.pop_front());
    if (complete && q.size() == 0) begin
      for (int i = 0; i < N; i++) q.push_back(OW'(cnew[i]));
      m_mask = dup;
      for (int i = 0; i < N; i++) m_cap[i] = dup[i] ? d[i*IW +: IW] : cnew[i];
    end else begin
      if (complete) begin
        m_pend = 1'b1;
        for (int i = 0; i < N; i++) m_pframe[i] = OW'(cnew[i]);
      end
      if (dup != '0) m_ovf = 1'b1;
      m_mask = mnew;
      for (int i = 0; i < N; i++) m_cap[i] = cnew[i];
    end
    if (last_acc && pend_old) begin
      for (int i = 0; i < N; i++) q.push_back(m_pframe[i]);
      m_pend = 1'b0;
      m_mask = '0;
    end
  endtask

  task automatic check_outputs();
    check_eq("dout_valid", 32'(dout_valid), 32'(q.size() > 0));
    check_eq("busy", 32'(busy), 32'((q.size() > 0) || m_pend));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() > 0) begin
      check_eq("dout", 32'(dout), 32'(q[0]));
      check_eq("dout_last", 32'(dout_last), 32'(q.size() == 1));
    end
  endtask

  // One clock: drive inputs after a negedge, update model at posedge, check at next negedge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*IW-1:0] d, input logic r);
    nv   = v;
    nout = d;
    rdy  = r;
    @(posedge clk);
    model_step(v, d, r);
    @(negedge clk);
    nv = '0;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nv  = '0;
    rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_dout", 32'(dout), 32'h0);
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    nout = '0;
    do_reset();

    // Separate pulses, ready high.
    cycle(4'b0001, pack4(8'h11, 8'h00, 8'h00, 8'h00), 1'b1);
    cycle(4'b0010, pack4(8'h00, 8'h22, 8'h00, 8'h00), 1'b1);
    cycle(4'b0100, pack4(8'h00, 8'h00, 8'h33, 8'h00), 1'b1);
    cycle(4'b1000, pack4(8'h00, 8'h00, 8'h00, 8'h44), 1'b1);
    check_eq("t1_first", 32'(dout), 32'h0011);
    repeat (6) cycle('0, '0, 1'b1);

    // All bits in one cycle, zero extension.
    cycle(4'b1111, pack4(8'hFF, 8'h00, 8'h80, 8'h01), 1'b1);
    check_eq("t2_first", 32'(dout), 32'h00FF);
    repeat (6) cycle('0, '0, 1'b1);

    // Ready toggling holds words.
    cycle(4'b1111, pack4(8'hA1, 8'hB2, 8'hC3, 8'hD4), 1'b0);
    for (int k = 0; k < 16; k++) cycle('0, '0, (k % 3) == 0);

    // Back-to-back frames via pending.
    cycle(4'b1111, pack4(8'h01, 8'h02, 8'h03, 8'h04), 1'b1);
    cycle(4'b0011, pack4(8'h05, 8'h06, 8'h00, 8'h00), 1'b1);
    cycle(4'b1100, pack4(8'h00, 8'h00, 8'h07, 8'h08), 1'b1);
    repeat (8) cycle('0, '0, 1'b1);

    // Asynchronous reset during the 2nd word.
    cycle(4'b1111, pack4(8'h21, 8'h22, 8'h23, 8'h24), 1'b1);
    cycle('0, '0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_dout", 32'(dout), 32'h0);
    check_eq("arst_valid", 32'(dout_valid), 32'h0);
    check_eq("arst_last", 32'(dout_last), 32'h0);
    check_eq("arst_busy", 32'(busy), 32'h0);
    check_eq("arst_ovf", 32'(overflow), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(4'b1111, pack4(8'h31, 8'h32, 8'h33, 8'h34), 1'b1);
    check_eq("post_rst_first", 32'(dout), 32'h0031);
    repeat (6) cycle('0, '0, 1'b1);

    // Pulse while pending sets overflow.
    cycle(4'b1111, pack4(8'h41, 8'h42, 8'h43, 8'h44), 1'b0);
    cycle(4'b1111, pack4(8'h51, 8'h52, 8'h53, 8'h54), 1'b0);
    cycle(4'b0001, pack4(8'h99, 8'h00, 8'h00, 8'h00), 1'b0);
    check_eq("pend_ovf", 32'(overflow), 32'h1);
    repeat (12) cycle('0, '0, 1'b1);

    // Duplicate pulse before completion: first value kept, overflow sticky.
    do_reset();
    cycle(4'b0100, pack4(8'h00, 8'h00, 8'h5A, 8'h00), 1'b1);
    cycle(4'b0100, pack4(8'h00, 8'h00, 8'hA5, 8'h00), 1'b1);
    check_eq("dup_ovf", 32'(overflow), 32'h1);
    cycle(4'b1011, pack4(8'h61, 8'h62, 8'h00, 8'h64), 1'b1);
    repeat (6) cycle('0, '0, 1'b1);
    check_eq("dup_sticky", 32'(overflow), 32'h1);

    // Random traffic in several reset-separated segments.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int k = 0; k < 150; k++) begin
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 5) == 0);
        cycle(v, N*IW'($urandom), $urandom_range(0, 3) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_output_serializer.md
Name: layer_output_serializer

Overview:
- Downstream stage of a layer of neurons. Collects the per-neuron activation outputs of one layer, each arriving with its own one-cycle valid pulse.
- Once all NUM_NEURONS results are in, streams them in neuron-index order, one word per cycle, as the input stream of the next layer (its input-data / input-valid pair).
- Double-buffered, so layer N can produce the next frame while the current frame is still streaming.

Parameters:
- NUM_NEURONS, 30: number of neurons in the producing layer (frame length); must be >= 2.
- IN_WIDTH, 8: width of each neuron activation output (ROM output width).
- OUT_WIDTH, 16: width of each streamed word (next-layer data width).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- neuron_valid  in  NUM_NEURONS  bit i is a one-cycle pulse: neuron i's output is valid.
- neuron_out  in  NUM_NEURONS*IN_WIDTH  packed outputs; neuron i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- dout_ready  in  1  downstream accepts a word this cycle.
- dout  out  OUT_WIDTH  streamed word.
- dout_valid  out  1  dout is valid.
- dout_last  out  1  high with the final word (index NUM_NEURONS-1) of a frame.
- overflow  out  1  sticky error flag; cleared only by rst.
- busy  out  1  high while a frame is pending or streaming.

Behaviour:
- Reset: dout=0, dout_valid=0, dout_last=0, overflow=0, busy=0, capture mask cleared, send index=0, state IDLE. Reset asserted mid-frame discards all buffered data immediately.
- Capture bank:
  - NUM_NEURONS x IN_WIDTH registers plus a captured mask.
  - On a clock edge with neuron_valid[i]=1, store slot i and set mask[i]. Several bits may be set in the same cycle; all are captured.
  - Width rule: when IN_WIDTH < OUT_WIDTH, the stored value is zero-extended into OUT_WIDTH (activations are unsigned). When IN_WIDTH >= OUT_WIDTH, the upper OUT_WIDTH bits are used.
  - Capture is complete when mask is all ones, including bits set on the current edge.
- Send bank: NUM_NEURONS x OUT_WIDTH registers plus a send index of $clog2(NUM_NEURONS) bits.
- State machine:
  - IDLE → SEND: on the edge where capture completes, transfer capture bank to send bank, clear mask, index=0, go to SEND. dout_valid rises on the next cycle, so latency is 1 cycle from the last neuron_valid edge to the first word.
  - SEND: dout = send_bank[index], dout_valid=1. On dout_valid & dout_ready, index increments. dout_last=1 when index==NUM_NEURONS-1. dout holds stable while dout_ready=0.
  - Frame end: when the last word is accepted, go to IDLE, or start the next frame directly if one is pending.
  - PENDING (flag): set when capture completes while SEND is active. The capture bank is frozen and not cleared.
    - When the last word is accepted with the pending flag set, transfer the capture bank on that same edge, clear mask and flag, stay in SEND with index=0. The stream has no bubble.
    - If capture completes on the same edge the last word is accepted, transfer directly on that edge. This is not an overflow.
- Overflow: set in either of these cases; the new data is dropped and captured data is kept.
  - neuron_valid[i] arrives while mask[i] is already set and not cleared on that edge.
  - Any neuron_valid arrives while the pending flag is set.
- busy = (state==SEND) | pending.
- Index wrap: index returns to 0 after NUM_NEURONS-1. It never exceeds NUM_NEURONS-1.

Test Plan:
- NUM_NEURONS=4, IN=8, OUT=16, dout_ready=1. Pulse neurons 0..3 on separate cycles with 0x11, 0x22, 0x33, 0x44 → one cycle after the neuron-3 pulse, dout = 0x0011, 0x0022, 0x0033, 0x0044 on consecutive cycles; dout_last only on 0x0044; then dout_valid=0.
- Pulse all 4 bits in one cycle, values 0xFF, 0x00, 0x80, 0x01 → stream 0x00FF, 0x0000, 0x0080, 0x0001. Width check: zero-extension.
- Toggle dout_ready 1,0,0,1,... during a frame → each word is held stable while ready=0; no word skipped or duplicated; dout_last on the 4th accepted word.
- Complete frame B while frame A streams (ready=1) → A's 4 words are followed immediately by B's 4 words with no gap; busy stays high throughout; overflow=0.
- Pulse neuron 2 twice before the frame completes → overflow=1 and sticky; the streamed slot 2 holds the first value. A further pulse while pending also leaves overflow=1.
- Assert rst during the 2nd word of a frame → all outputs 0 immediately (asynchronous). A fresh frame after release streams correctly from index 0.
